// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: shared forward encodings, FSM states and scoreboard slot layout
package hazard_forward_ctrl_pkg;
  localparam int REG_W = 3;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LDSTALL = 2'd1, ST_FROZEN = 2'd2} state_e;
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } slot_t;
  function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] r);
    return s.vld && s.wr && s.rd == r;
  endfunction
endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: ID-stage request bundle in, forward/stall/kill controls and counters out
// master drives id_* and mem_wait; slave (the controller) drives forward_*, stall, kill_if, bubble_ex, counters
interface hazard_forward_ctrl_if #(parameter int CNT_W = 16);
  import hazard_forward_ctrl_pkg::*;
  logic             id_valid;
  logic [REG_W-1:0] id_ra;
  logic [REG_W-1:0] id_rb;
  logic             id_use_a;
  logic             id_use_b;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_redirect;
  logic             mem_wait;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall;
  logic             kill_if;
  logic             bubble_ex;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd, id_reg_write, id_mem_read,
           id_redirect, mem_wait,
    input  forward_a, forward_b, stall, kill_if, bubble_ex, stall_count, flush_count
  );
  modport slave (
    input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd, id_reg_write, id_mem_read,
           id_redirect, mem_wait,
    output forward_a, forward_b, stall, kill_if, bubble_ex, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// hazard_forward_ctrl_fwd_select: prioritised EX>MEM>WB forward select for one source operand
// in: use_r, r, ex/mem/wb slots; out: sel (FWD_* code), ex_hit (EX slot produces r)
module hazard_forward_ctrl_fwd_select
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int ZERO_REG = 0
) (
  input  logic             use_r,
  input  logic [REG_W-1:0] r,
  input  slot_t            ex,
  input  slot_t            mem,
  input  slot_t            wb,
  output logic [1:0]       sel,
  output logic             ex_hit
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  logic live;
  always_comb begin
    live   = use_r && r != ZR;
    ex_hit = live && slot_hit(ex, r);
    sel    = ex_hit ? FWD_ALU : (live && slot_hit(mem, r)) ? FWD_MEM :
             (live && slot_hit(wb, r)) ? FWD_WB : FWD_REG;
  end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding selects, load-use stall, redirect kill and stall/flush counters
// ports: clk, rst_n (async active-low), bus (hazard_forward_ctrl_if.slave)
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_ctrl_if.slave  bus
);
  state_e           state_q, state_d;
  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  logic [1:0]       sel_a, sel_b;
  logic             ex_hit_a, ex_hit_b, hazard, ld_stall, stall, kill;
  hazard_forward_ctrl_fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .use_r(bus.id_use_a), .r(bus.id_ra), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(sel_a), .ex_hit(ex_hit_a)
  );
  hazard_forward_ctrl_fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .use_r(bus.id_use_b), .r(bus.id_rb), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(sel_b), .ex_hit(ex_hit_b)
  );
  // The load-use stall is raised combinationally in the cycle the hazard appears;
  // ST_LDSTALL marks the following cycle, where the load sits in MEM and must not re-stall.
  // Outputs are gated by rst_n so they read 0 throughout reset regardless of inputs.
  always_comb begin
    hazard        = ex_q.ld && (ex_hit_a || ex_hit_b);
    ld_stall      = rst_n && !bus.mem_wait && bus.id_valid && hazard && state_q != ST_LDSTALL;
    stall         = rst_n && (bus.mem_wait || ld_stall);
    kill          = rst_n && bus.id_redirect && bus.id_valid && !stall;
    state_d       = bus.mem_wait ? ST_FROZEN : ld_stall ? ST_LDSTALL : ST_RUN;
    wb_d          = bus.mem_wait ? wb_q : mem_q;
    mem_d         = bus.mem_wait ? mem_q : ex_q;
    ex_d          = bus.mem_wait ? ex_q : (bus.id_valid && !stall) ?
                    slot_t'{1'b1, bus.id_rd, bus.id_reg_write, bus.id_mem_read} : slot_t'('0);
    stall_count_d = stall_count_q + CNT_W'(ld_stall && !(&stall_count_q));
    flush_count_d = flush_count_q + CNT_W'(kill && !(&flush_count_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign bus.forward_a   = hazard ? FWD_REG : sel_a;
  assign bus.forward_b   = hazard ? FWD_REG : sel_b;
  assign bus.stall       = stall;
  assign bus.bubble_ex   = ld_stall;
  assign bus.kill_if     = kill;
  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;
endmodule
